// File: rtl/serial_subtractor_ctrl_if.sv
// serial_subtractor_ctrl_if: start/done handshake, operands and result of the bit-serial subtractor
interface serial_subtractor_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    modport master (output start, a, b, bin, input ready, busy, done, diff, bout, zero);
    modport slave  (input start, a, b, bin, output ready, busy, done, diff, bout, zero);
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: WIDTH-bit a - b - bin computed LSB first through one full_subtractor cell
module full_subtractor (
    input  logic i0,
    input  logic i1,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = i0 ^ i1 ^ bin;
    assign bout = (~i0 & i1) | (~(i0 ^ i1) & bin);
endmodule

module serial_subtractor_ctrl #(parameter int WIDTH = 8) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_subtractor_ctrl_if.slave s
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sd, diff_r, sd_nxt;
    logic [CW-1:0] cnt;
    logic br, bout_r, zero_r, d, cb, last;
    full_subtractor u_fs (.i0(sa[0]), .i1(sb[0]), .bin(br), .d(d), .bout(cb));
    assign last   = cnt == LAST;
    assign sd_nxt = {d, sd[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = s.start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            zero_r <= 1'b1;
        end else if (state == IDLE && s.start) begin
            sa  <= s.a;
            sb  <= s.b;
            br  <= s.bin;
            sd  <= '0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= sd_nxt;
            br  <= cb;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                diff_r <= sd_nxt;
                bout_r <= cb;
                zero_r <= ~|sd_nxt;
            end
        end
    end
    assign s.ready = state == IDLE;
    assign s.busy  = state == RUN;
    assign s.done  = state == DONE;
    assign s.diff  = diff_r;
    assign s.bout  = bout_r;
    assign s.zero  = zero_r;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: table vectors, random ops and exhaustive WIDTH=4 sweep against an arithmetic model
module tb_serial_subtractor_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errs = 0;
    int checks = 0;
    logic [7:0] prev8 = 8'h00;

    serial_subtractor_ctrl_if #(.WIDTH(8)) ifa ();
    serial_subtractor_ctrl_if #(.WIDTH(4)) ifb ();
    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .s(ifa));
    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .s(ifb));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b;
        logic       bin;
        logic [7:0] d;
        logic       bo, z, poke;
    } vec_t;
    vec_t tv[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic onehot8();
        chk("onehot8", 32'(int'(ifa.ready) + int'(ifa.busy) + int'(ifa.done)), 1);
    endtask

    task automatic op8(input logic [7:0] a, b, input logic bin,
                       input logic [7:0] ed, input logic eb, ez, input logic poke);
        int n;
        @(negedge clk);
        chk("ready_idle", ifa.ready, 1);
        ifa.a = a; ifa.b = b; ifa.bin = bin; ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.a = 8'($urandom); ifa.b = 8'($urandom); ifa.bin = 1'($urandom);
        n = 1;
        while (!ifa.done && n < 40) begin
            onehot8();
            chk("busy", ifa.busy, 1);
            chk("diff_hold", ifa.diff, prev8);
            ifa.start = poke && (n == 3 || n == 8);
            if (ifa.start) begin
                ifa.a = 8'($urandom); ifa.b = 8'($urandom); ifa.bin = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        chk("latency8", n - 1, 8);
        onehot8();
        chk("diff8", ifa.diff, ed);
        chk("bout8", ifa.bout, eb);
        chk("zero8", ifa.zero, ez);
        prev8 = ed;
        ifa.start = poke;
        if (poke) begin
            ifa.a = 8'($urandom); ifa.b = 8'($urandom);
            @(negedge clk);
            ifa.start = 1'b0;
            chk("ready_after_done", ifa.ready, 1);
            chk("no_second_done", ifa.done, 0);
            repeat (3) begin
                @(negedge clk);
                chk("idle_no_done", ifa.done, 0);
                chk("diff_after", ifa.diff, ed);
            end
        end
    endtask

    task automatic op4(input logic [3:0] a, b, input logic bin);
        int n, r;
        r = int'(a) - int'(b) - int'(bin);
        @(negedge clk);
        ifb.a = a; ifb.b = b; ifb.bin = bin; ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        n = 1;
        while (!ifb.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency4", n - 1, 4);
        chk("diff4", ifb.diff, r & 15);
        chk("bout4", ifb.bout, r < 0);
        chk("zero4", ifb.zero, (r & 15) == 0);
    endtask

    initial begin
        int r;
        logic [7:0] ra, rb;
        logic rbin;
        tv[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0};
        tv[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tv[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[4] = '{8'h33, 8'h22, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1};
        tv[5] = '{8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tv[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        ifa.start = 1'b0; ifa.a = '0; ifa.b = '0; ifa.bin = 1'b0;
        ifb.start = 1'b0; ifb.a = '0; ifb.b = '0; ifb.bin = 1'b0;
        #12;
        chk("rst_ready", ifa.ready, 1);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_diff", ifa.diff, 0);
        chk("rst_bout", ifa.bout, 0);
        chk("rst_zero", ifa.zero, 1);
        #5 rst_n = 1'b1;
        foreach (tv[i]) op8(tv[i].a, tv[i].b, tv[i].bin, tv[i].d, tv[i].bo, tv[i].z, tv[i].poke);
        repeat (40) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra;
            r = int'(ra) - int'(rb) - int'(rbin);
            op8(ra, rb, rbin, 8'(r & 255), r < 0, (r & 255) == 0, 1'($urandom_range(0, 5) == 0));
        end
        op8(8'hC3, 8'h41, 1'b0, 8'h82, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        ifa.a = 8'h9A; ifa.b = 8'h12; ifa.bin = 1'b1; ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ifa.ready, 1);
        chk("mid_rst_busy", ifa.busy, 0);
        chk("mid_rst_done", ifa.done, 0);
        chk("mid_rst_diff", ifa.diff, 0);
        chk("mid_rst_bout", ifa.bout, 0);
        chk("mid_rst_zero", ifa.zero, 1);
        #2 rst_n = 1'b1;
        prev8 = 8'h00;
        repeat (12) begin
            @(negedge clk);
            chk("no_done_after_rst", ifa.done, 0);
        end
        op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(4'(a), 4'(b), 1'(c));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial multi-bit subtractor that time-multiplexes a single `full_subtractor` cell over WIDTH clock cycles, LSB first, to compute `a - b - bin`. It holds the operands, tracks the bit position, carries the borrow between cycles and presents the result through a start/done handshake. It is the sequencing layer that turns the 1-bit subtractor datapath into a WIDTH-bit arithmetic resource for the ALU.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only while `ready`=1.
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- bin  in  1  borrow-in to bit 0; captured on the accepting edge.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN only.
- done  out  1  one-cycle pulse when the result becomes valid.
- diff  out  WIDTH  result register, `(a - b - bin) mod 2^WIDTH`.
- bout  out  1  final borrow; 1 iff `a < b + bin` (unsigned).
- zero  out  1  1 iff `diff` = 0; valid with `diff`.

## Operation
- Three states: IDLE, RUN and DONE. The encoding is free.
- IDLE -> RUN when `start`=1 at a clock edge. On that edge:
  - latch `a`/`b` into shift registers `sa`/`sb`;
  - latch `bin` into borrow flop `br`;
  - clear bit counter `cnt` and working shift register `sd`.
- IDLE with `start`=0: stay in IDLE.
- Every RUN edge:
  - the cell computes from `i0`=`sa[0]`, `i1`=`sb[0]`, `bin`=`br`;
  - `sd` shifts right with the cell's `d` entering the MSB;
  - `sa` and `sb` shift right;
  - `br` takes the cell's `bout`;
  - `cnt` increments.
- RUN -> DONE on the edge where `cnt`=WIDTH-1, i.e. the WIDTH-th RUN edge. On that same edge:
  - load `diff` from the final shifted value of `sd`, including that edge's bit;
  - load `bout` from that edge's cell borrow;
  - load `zero` from the final `diff` value.
- DONE -> IDLE unconditionally on the next edge. `done`=1 only while in DONE.
- `start` during RUN or DONE is ignored and not queued. `a`, `b` and `bin` may change freely after the accepting edge.
- `diff`, `bout` and `zero` change only on the RUN->DONE edge. They hold their value through IDLE and the following RUN until the next completion.
- `cnt` is `$clog2(WIDTH)` bits wide and never wraps within an operation.
- Reset (`rst_n`=0, at any time including mid-RUN) immediately forces:
  - state = IDLE;
  - `ready`=1, `busy`=0, `done`=0;
  - `diff`=0, `bout`=0, `zero`=1;
  - `sa`, `sb`, `sd`, `br`, `cnt` all cleared.
  - An in-flight operation is discarded. No `done` is produced for it.

## Timing
- Accepting edge is E0. RUN edges are E1..EWIDTH. The state is DONE during the cycle after EWIDTH.
- Latency from the accepting edge to `done` high is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles, since `ready` returns one cycle after `done`.
- `ready`, `busy` and `done` are mutually exclusive and exactly one is high at all times. All three are registered-state decodes with no combinational path from `start`.
- Release of `rst_n` is asynchronous. The first accepting edge may be the first clock edge after deassertion.

## Test plan
- WIDTH=8: `a`=0x5A, `b`=0x3C, `bin`=0, pulse `start` -> `done` exactly 8 cycles after the accepting edge; `diff`=0x1E, `bout`=0, `zero`=0.
- `a`=0x00, `b`=0x01, `bin`=0 -> `diff`=0xFF, `bout`=1. Then `a`=0xFF, `b`=0xFF, `bin`=1 -> `diff`=0xFF, `bout`=1.
- `a`=0x10, `b`=0x0F, `bin`=1 -> `diff`=0x00, `bout`=0, `zero`=1.
  - Between operations, `diff` holds 0x00 through IDLE and the next RUN until the next `done`.
- Pulse `start` with new operands at cycles 3 and 8 of a RUN, and during DONE -> all ignored.
  - The first result is unaffected.
  - `ready` rises the cycle after `done`.
  - Exactly one `done` pulse occurs.
- Assert `rst_n`=0 mid-RUN (after cycle 4 of 8) -> immediately `ready`=1, `busy`=0, `diff`=0, `bout`=0, `zero`=1.
  - No `done` follows.
  - A fresh `a`=0x80, `b`=0x01 operation then yields `diff`=0x7F, `bout`=0.
- Exhaustive check with WIDTH=4: all 512 (`a`, `b`, `bin`) combinations against a reference model -> `diff`, `bout` and `zero` match every time.
  - `done` always comes 4 cycles after acceptance.
